// File: rtl/traffic_light_seq.sv
// traffic_light_seq: two-road traffic light sequencer stepped by a synchronized 1 Hz tick.
// Optional pedestrian request feature is enabled by defining the macro PED_REQUEST_EN.
// Ports:
//   clk_100MHz     in   system clock, all state on its rising edge
//   reset          in   asynchronous active-high reset
//   clk_1Hz        in   slow square wave, each rising edge is one second
//   ped_req        in   pedestrian button, level (PED_REQUEST_EN only)
//   walk           out  pedestrian walk lamp, lit for the whole EW_GREEN phase (PED_REQUEST_EN only)
//   ns_light       out  north-south lamps {red,yellow,green}, one-hot
//   ew_light       out  east-west lamps {red,yellow,green}, one-hot
//   sec_remaining  out  seconds left in the current phase
module traffic_light_seq #(
  parameter int GREEN_S   = 20,
  parameter int YELLOW_S  = 3,
  parameter int ALLRED_S  = 1,
  parameter int PED_MIN_S = 5
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       clk_1Hz,
`ifdef PED_REQUEST_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [5:0] sec_remaining
);
  typedef enum logic [2:0] {NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B} state_t;
  state_t state, state_n;
  logic [5:0] sec_n;
  logic [2:0] ns_n, ew_n;
  logic s1, s2, hist, arm, tick, flag, shorten;
  logic [1:0] fill;
  // fill marks when s2 carries a real sample of clk_1Hz rather than its reset value,
  // so a clk_1Hz held high across reset release cannot arm a spurious tick
  always_ff @(posedge clk_100MHz or posedge reset)
    if (reset) {s1, s2, hist, arm, fill} <= '0;
    else begin
      s1   <= clk_1Hz;
      s2   <= s1;
      hist <= s2;
      fill <= {fill[0], 1'b1};
      arm  <= arm | (fill[1] & ~s2);
    end
  assign tick = s2 & ~hist & arm;
  function automatic state_t succ(state_t s);
    return s == NS_GREEN  ? NS_YELLOW :
           s == NS_YELLOW ? ALLRED_A  :
           s == ALLRED_A  ? EW_GREEN  :
           s == EW_GREEN  ? EW_YELLOW :
           s == EW_YELLOW ? ALLRED_B  : NS_GREEN;
  endfunction
  function automatic logic [5:0] dur(state_t s);
    return (s == NS_GREEN  || s == EW_GREEN)  ? 6'(GREEN_S)  :
           (s == NS_YELLOW || s == EW_YELLOW) ? 6'(YELLOW_S) : 6'(ALLRED_S);
  endfunction
  assign shorten = flag && state == NS_GREEN && sec_remaining > 6'(PED_MIN_S);
  always_comb begin
    state_n = (tick && sec_remaining == 6'd1) ? succ(state) : state;
    sec_n   = !tick                  ? sec_remaining :
              sec_remaining == 6'd1  ? dur(state_n) :
              shorten                ? 6'(PED_MIN_S) : sec_remaining - 6'd1;
    ns_n    = state_n == NS_GREEN  ? 3'b001 : state_n == NS_YELLOW ? 3'b010 : 3'b100;
    ew_n    = state_n == EW_GREEN  ? 3'b001 : state_n == EW_YELLOW ? 3'b010 : 3'b100;
  end
  always_ff @(posedge clk_100MHz or posedge reset)
    if (reset) begin
      state         <= ALLRED_B;
      sec_remaining <= 6'(ALLRED_S);
      ns_light      <= 3'b100;
      ew_light      <= 3'b100;
    end else begin
      state         <= state_n;
      sec_remaining <= sec_n;
      ns_light      <= ns_n;
      ew_light      <= ew_n;
    end
`ifdef PED_REQUEST_EN
  logic p1, p2;
  // a request seen during EW_GREEN survives because the flag only clears on entry
  always_ff @(posedge clk_100MHz or posedge reset)
    if (reset) {p1, p2, flag, walk} <= '0;
    else begin
      p1   <= ped_req;
      p2   <= p1;
      flag <= (flag & ~(state_n == EW_GREEN && state != EW_GREEN)) | p2;
      walk <= state_n == EW_GREEN;
    end
`else
  assign flag = 1'b0;
`endif
endmodule

// File: tb/tb_traffic_light_seq.sv
// tb_traffic_light_seq: self-checking bench for traffic_light_seq (table vectors, directed corners, random vs phase model).
module tb_traffic_light_seq;
  localparam int G = 4, Y = 2, AR = 1, PM = 2;
  logic clk_100MHz = 0, reset = 1, clk_1Hz = 0, ped_req = 0, walk, mon_en = 0;
  logic [2:0] ns_light, ew_light;
  logic [5:0] sec_remaining;
  int tests = 0, fails = 0, hi, lo;
  always #5 clk_100MHz = ~clk_100MHz;
  traffic_light_seq #(.GREEN_S(G), .YELLOW_S(Y), .ALLRED_S(AR), .PED_MIN_S(PM)) dut (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .clk_1Hz(clk_1Hz),
`ifdef PED_REQUEST_EN
    .ped_req(ped_req),
    .walk(walk),
`endif
    .ns_light(ns_light),
    .ew_light(ew_light),
    .sec_remaining(sec_remaining)
  );
`ifndef PED_REQUEST_EN
  assign walk = 1'b0;
`endif
  // phase model: index into the six-phase cycle, seconds left, pending request
  logic [2:0] ns_tab [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
  int dur_tab [6] = '{G, Y, AR, G, Y, AR};
  int idx = 5, msec = AR;
  bit mflag = 0;
  typedef struct packed {int hi; int lo; logic [2:0] ns; logic [2:0] ew; logic [5:0] sec;} vec_t;
  vec_t tv [12];
  function automatic logic exp_walk();
`ifdef PED_REQUEST_EN
    return idx == 3;
`else
    return 1'b0;
`endif
  endfunction
  task automatic model_reset();
    idx = 5; msec = AR; mflag = 0;
  endtask
  task automatic model_tick();
    if (msec == 1) begin
      idx = (idx + 1) % 6;
      msec = dur_tab[idx];
      if (idx == 3) mflag = 0;
    end else if (idx == 0 && mflag && msec > PM) msec = PM;
    else msec = msec - 1;
  endtask
  task automatic chk(string nm, logic [2:0] ns_e, logic [2:0] ew_e, logic [5:0] sec_e, logic walk_e);
    tests++;
    if (ns_light !== ns_e || ew_light !== ew_e || sec_remaining !== sec_e || walk !== walk_e) begin
      fails++;
      $display("FAIL %s: got ns=%b ew=%b sec=%0d walk=%b, want ns=%b ew=%b sec=%0d walk=%b",
               nm, ns_light, ew_light, sec_remaining, walk, ns_e, ew_e, sec_e, walk_e);
    end
  endtask
  task automatic chk_model(string nm);
    chk(nm, ns_tab[idx], ew_tab[idx], 6'(msec), exp_walk());
  endtask
  // raise clk_1Hz, expect no change after two edges and the step on the third, then hold high
  task automatic rise(string nm, int h);
    @(negedge clk_100MHz) clk_1Hz = 1;
    repeat (2) @(posedge clk_100MHz);
    @(negedge clk_100MHz) chk_model({nm, "_pre"});
    @(posedge clk_100MHz) model_tick();
    @(negedge clk_100MHz) chk_model(nm);
    repeat (h - 3) @(negedge clk_100MHz);
  endtask
  task automatic fall(int l);
    @(negedge clk_100MHz) clk_1Hz = 0;
    repeat (l) @(negedge clk_100MHz);
  endtask
  task automatic do_reset();
    @(negedge clk_100MHz) reset = 1;
    model_reset();
    #1 chk("reset_async", 3'b100, 3'b100, 6'(AR), 1'b0);
    repeat (3) @(negedge clk_100MHz);
    reset = 0;
  endtask
  task automatic ped_pulse();
    @(negedge clk_100MHz) ped_req = 1;
    mflag = 1;
    @(negedge clk_100MHz) ped_req = 0;
  endtask
  always @(negedge clk_100MHz)
    if (mon_en) begin
      tests++;
      if (!$onehot(ns_light) || !$onehot(ew_light) || (ns_light != 3'b100 && ew_light != 3'b100) ||
          (!reset && sec_remaining == 6'd0)) begin
        fails++;
        $display("FAIL invariant: got ns=%b ew=%b sec=%0d, want one-hot, one road red, sec nonzero",
                 ns_light, ew_light, sec_remaining);
      end
    end
  initial begin
    tv[0]  = '{200, 200, 3'b001, 3'b100, 6'd4};
    tv[1]  = '{3,   2,   3'b001, 3'b100, 6'd3};
    tv[2]  = '{200, 200, 3'b001, 3'b100, 6'd2};
    tv[3]  = '{50,  7,   3'b001, 3'b100, 6'd1};
    tv[4]  = '{200, 200, 3'b010, 3'b100, 6'd2};
    tv[5]  = '{200, 200, 3'b010, 3'b100, 6'd1};
    tv[6]  = '{3,   3,   3'b100, 3'b100, 6'd1};
    tv[7]  = '{200, 200, 3'b100, 3'b001, 6'd4};
    tv[8]  = '{200, 200, 3'b100, 3'b001, 6'd3};
    tv[9]  = '{200, 200, 3'b100, 3'b001, 6'd2};
    tv[10] = '{200, 200, 3'b100, 3'b001, 6'd1};
    tv[11] = '{200, 200, 3'b100, 3'b010, 6'd2};
    repeat (3) @(negedge clk_100MHz);
    chk("reset_state", 3'b100, 3'b100, 6'(AR), 1'b0);
    reset = 0;
    mon_en = 1;
    repeat (10) @(negedge clk_100MHz);
    for (int i = 0; i < 12; i++) begin
      rise("seq", tv[i].hi);
      chk($sformatf("seq_vec%0d", i), tv[i].ns, tv[i].ew, tv[i].sec, exp_walk());
      fall(tv[i].lo);
    end
    rise("long_high", 10000);
    chk("long_high_once", 3'b100, 3'b010, 6'd1, 1'b0);
    fall(50);
    for (int k = 0; k < 12 && idx != 3; k++) begin
      rise("to_ewg", 53);
      if (idx != 3) fall(100);
    end
    chk("in_ewg", 3'b100, 3'b001, 6'(G), exp_walk());
    do_reset();
    repeat (250) @(negedge clk_100MHz);
    chk("hold_high_250", 3'b100, 3'b100, 6'd1, 1'b0);
    repeat (250) @(negedge clk_100MHz);
    chk_model("hold_high_500");
    fall(20);
    rise("after_reset", 200);
    chk("after_reset_nsg", 3'b001, 3'b100, 6'(G), 1'b0);
`ifdef PED_REQUEST_EN
    ped_pulse();
    fall(100);
    rise("ped", 200);
    chk("ped_short", 3'b001, 3'b100, 6'(PM), 1'b0);
    fall(100);
    rise("ped", 200);
    chk("ped_last", 3'b001, 3'b100, 6'd1, 1'b0);
    fall(100);
    rise("ped", 200);
    chk("ped_yellow", 3'b010, 3'b100, 6'(Y), 1'b0);
    for (int k = 0; k < 3; k++) begin
      fall(100);
      rise("ped_to_ewg", 200);
    end
    chk("ped_walk", 3'b100, 3'b001, 6'(G), 1'b1);
    ped_pulse();
    for (int k = 0; k < 4; k++) begin
      fall(100);
      rise("ped_walk_end", 200);
    end
    chk("walk_off", 3'b100, 3'b010, 6'(Y), 1'b0);
`endif
    fall(50);
    for (int i = 0; i < 40; i++) begin
      hi = $urandom_range(3, 300);
      lo = $urandom_range(12, 300);
      rise("rand", hi);
      @(negedge clk_100MHz) clk_1Hz = 0;
`ifdef PED_REQUEST_EN
      if ($urandom_range(0, 3) == 0) ped_pulse();
`endif
      if ($urandom_range(0, 9) == 0) do_reset();
      repeat (lo) @(negedge clk_100MHz);
    end
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/traffic_light_seq.md
TRAFFIC_LIGHT_SEQ -- requirements
Module: traffic_light_seq

Interface
REQ-001 Parameter GREEN_S, default 20: green phase length, seconds, range 1..63.
REQ-002 Parameter YELLOW_S, default 3: yellow phase length, seconds, range 1..63.
REQ-003 Parameter ALLRED_S, default 1: all-red clearance length, seconds, range 1..63.
REQ-004 Parameter PED_MIN_S, default 5: shortened green remainder on pedestrian request, range 1..63.
REQ-005 clk_100MHz  in  1  system clock, 100 MHz, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clock clk_100MHz.
REQ-007 clk_1Hz  in  1  slow square wave, asynchronous to clk_100MHz; each rising edge is one second.
REQ-008 ped_req  in  1  pedestrian button, level, asynchronous (present only with PED_REQUEST_EN).
REQ-009 ns_light  out  3  north-south lamps {red,yellow,green}, one-hot, registered.
REQ-010 ew_light  out  3  east-west lamps {red,yellow,green}, one-hot, registered.
REQ-011 sec_remaining  out  6  seconds left in current phase, registered.
REQ-012 walk  out  1  pedestrian walk lamp (present only with PED_REQUEST_EN).

Function
REQ-013 clk_1Hz SHALL pass a 2-flop synchronizer plus a history flop; tick = one-cycle pulse when sync output is 1 and history is 0.
REQ-014 tick SHALL assert in the 3rd clk_100MHz cycle after clk_1Hz rises; a high level of any length SHALL yield exactly one tick.
REQ-015 An arm flag SHALL suppress tick until the synchronized clk_1Hz has been observed low at least once after reset.
REQ-016 States SHALL cycle NS_GREEN -> NS_YELLOW -> ALLRED_A -> EW_GREEN -> EW_YELLOW -> ALLRED_B -> NS_GREEN; no other transitions.
REQ-017 Durations: *_GREEN = GREEN_S, *_YELLOW = YELLOW_S, ALLRED_* = ALLRED_S.
REQ-018 On tick with sec_remaining == 1, the FSM SHALL advance and load the next state's duration in the same cycle.
REQ-019 On tick with sec_remaining > 1, sec_remaining SHALL decrement by 1; without tick it SHALL hold.
REQ-020 Lamp outputs SHALL update in the cycle following the tick that causes a transition (registered from next state).
REQ-021 Lamps: NS_GREEN ns=001 ew=100; NS_YELLOW ns=010 ew=100; ALLRED_* both 100; EW_GREEN ns=100 ew=001; EW_YELLOW ns=100 ew=010.
REQ-022 At no cycle SHALL ns_light and ew_light both differ from 100.
REQ-023 sec_remaining SHALL never be 0 outside reset.

Reset
REQ-024 Reset SHALL force state ALLRED_B, ns_light=100, ew_light=100, sec_remaining=ALLRED_S immediately, regardless of clock.
REQ-025 Reset SHALL clear synchronizer, history and arm flops to 0; walk=0; pedestrian request flag=0.
REQ-026 Reset asserted mid-phase SHALL discard the phase; after release, sequencing restarts from ALLRED_B.

Configuration
REQ-027 Macro PED_REQUEST_EN defined: ped_req (2-flop synchronized) sets a sticky request flag.
REQ-028 With PED_REQUEST_EN, on tick in NS_GREEN with flag set and sec_remaining > PED_MIN_S, sec_remaining SHALL load PED_MIN_S instead of decrementing.
REQ-029 With PED_REQUEST_EN, the flag SHALL clear on entry to EW_GREEN, and walk SHALL be 1 for all of that EW_GREEN phase only; a request during EW_GREEN stays pending for the next NS_GREEN.
REQ-030 PED_REQUEST_EN undefined: ped_req and walk ports absent, timing fixed per REQ-017.

Verification (GREEN_S=4, YELLOW_S=2, ALLRED_S=1, PED_MIN_S=2; clk_1Hz period 200 cycles unless noted)
REQ-031 Reset, then 12 clk_1Hz edges -> NS_GREEN 4 s (sec 4,3,2,1), NS_YELLOW 2 s, ALLRED_A 1 s, EW_GREEN 4 s, EW_YELLOW 2 s; lamps per REQ-021, change 1 cycle after tick.
REQ-032 Assert reset 50 cycles into EW_GREEN -> same cycle ns=ew=100, sec_remaining=1; after release, first tick enters NS_GREEN with sec_remaining=4.
REQ-033 clk_1Hz held high across reset release for 500 cycles, then low, then high -> no tick until that low-to-high; sec_remaining unchanged until then.
REQ-034 clk_1Hz high for 10000 cycles -> exactly one decrement, 3 cycles after the edge.
REQ-035 PED_REQUEST_EN: 1-cycle ped_req pulse at NS_GREEN sec_remaining=4 -> next tick sec_remaining=2, then 1, NS_YELLOW; walk=1 throughout following EW_GREEN, 0 elsewhere.
REQ-036 Every run: assertion REQ-022 and REQ-023 hold on every cycle; ns/ew always one-hot.
